mole_spawner: RTL and testbench
===============================

// Module: mole_spawner
// PURPOSE
//  Upstream stage of the mole display decoder. Picks a pseudo-random hole index and holds it on
//  number[4:0] for a visible window. Detects a hit on that hole or a timeout, then blanks
//  between moles. number=0..17 lights one LED downstream; BLANK (31) lights none.
// PARAMETERS
//  NUM_HOLES   18        valid hole indices are 0..NUM_HOLES-1 (max 31)
//  UP_CYCLES   25000000  max cycles a mole stays visible (0.5 s @ 50 MHz); >=1
//  GAP_CYCLES  12500000  blank cycles between moles (0.25 s @ 50 MHz); >=1
//  LFSR_SEED   16'hACE1  LFSR reset value; must be non-zero
//  BLANK       5'd31     number value meaning "no mole"
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   synchronous reset, active low
//  start      in   1   1-cycle pulse: begin game (ignored unless IDLE)
//  stop       in   1   level/pulse: abort to IDLE
//  hit_req    in   18  1-cycle pulses per hole, debounced and synchronised upstream
//  number     out  5   current mole index, or BLANK
//  mole_hit   out  1   1-cycle pulse: correct hole hit while mole up
//  mole_miss  out  1   1-cycle pulse: mole timed out unhit
//  wrong_hit  out  1   1-cycle pulse: hit_req on any non-mole hole while UP
//  active     out  1   high in every state except IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset: state=IDLE, number=BLANK, all pulses=0, active=0,
//    LFSR=LFSR_SEED, prev_pos=BLANK, counter=0.
//  - LFSR: 16-bit Galois, poly x^16+x^14+x^13+x^11+1. Free-running: advances every cycle
//    after reset, so start timing seeds the sequence.
//  - FSM states:
//    IDLE: number=BLANK. On start -> GAP next cycle with counter=GAP_CYCLES-1.
//    GAP: number=BLANK. Lasts exactly GAP_CYCLES cycles. At counter==0 -> PICK.
//    PICK: candidate=LFSR[4:0]. Accept if candidate<NUM_HOLES and candidate!=prev_pos.
//      On accept: -> UP, number=candidate, prev_pos=candidate, counter=UP_CYCLES-1.
//      On reject: stay in PICK and retry next cycle. PICK takes >=1 cycle, no upper bound.
//    UP: number=pos.
//      If hit_req[pos]: mole_hit=1 -> GAP.
//      Else if counter==0: mole_miss=1 -> GAP.
//      Else decrement counter.
//      Any hit_req bit other than pos set: wrong_hit=1 in the same registered update.
//      This can coincide with mole_hit.
//  - Pulse timing: mole_hit/mole_miss assert in the first GAP cycle, the same cycle number
//    returns to BLANK. Max mole visibility is UP_CYCLES cycles.
//  - Priority, highest first: rst_n=0 > stop > hit on final UP cycle (hit wins over timeout)
//    > timeout.
//  - stop in any state: -> IDLE next cycle, number=BLANK, no hit/miss pulse. LFSR keeps running.
//    If stop and start are both high in IDLE, stay in IDLE.
//  - start outside IDLE is ignored. hit_req outside UP is ignored, so wrong_hit stays 0.
//  - Reset mid-UP: number=BLANK the next cycle. No pulse is emitted.
//  - Counter width is $clog2(max(UP_CYCLES,GAP_CYCLES)+1).
//  - number never takes a value in NUM_HOLES..30.
// TESTING (bench uses UP_CYCLES=8, GAP_CYCLES=4, default seed)
//  1 Reset held 3 cycles, then released -> number=31, active=0, pulses 0. Stays idle with no start.
//  2 start pulse -> active=1 next cycle. number=31 for exactly 4 cycles, then a value in 0..17
//    after >=1 PICK cycle.
//  3 Mole up, no hit_req -> number held 8 cycles. Then mole_miss=1 for 1 cycle with number=31.
//    Next mole != previous.
//  4 Mole up at pos p, hit_req=1<<p on 3rd UP cycle -> mole_hit=1 next cycle, number=31.
//    Also drive hit_req=(1<<p)|(1<<((p+1)%18)) -> mole_hit=1 and wrong_hit=1.
//  5 hit_req[p] on the final (8th) UP cycle -> mole_hit=1, mole_miss=0.
//  6 stop mid-UP -> IDLE next cycle, number=31, no pulses. Run 200 moles: every number
//    is <18, no repeat, and 31 between moles.

Source files
------------

// File: rtl/mole_spawner.sv
// Mole spawner: picks a pseudo-random hole, holds it for a visible window, then blanks.
// Reports hit, timeout and wrong-hole events as registered single-cycle pulses.
module mole_spawner #(
  parameter int unsigned NUM_HOLES  = 18,
  parameter int unsigned UP_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES = 12500000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [4:0]  BLANK      = 5'd31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_HOLES-1:0] hit_req,
  output logic [4:0]           number,
  output logic                 mole_hit,
  output logic                 mole_miss,
  output logic                 wrong_hit,
  output logic                 active
);

  localparam int unsigned MaxCycles = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] UpLoad  = CntW'(UP_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);
  localparam logic [4:0]      NumHoles5 = 5'(NUM_HOLES);

  typedef enum logic [1:0] {StIdle, StGap, StPick, StUp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [4:0]          number_q, number_d;
  logic [4:0]          prev_q, prev_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic                wrong_q, wrong_d;
  logic                active_q, active_d;
  logic [NUM_HOLES-1:0] pos_mask;
  logic                hit_c, wrong_c;
  logic [4:0]          cand;

  always_comb begin
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    pos_mask = NUM_HOLES'(1) << number_q;
    hit_c    = |(hit_req & pos_mask);
    wrong_c  = |(hit_req & ~pos_mask);
    cand     = lfsr_q[4:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    number_d = number_q;
    prev_d   = prev_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    wrong_d  = 1'b0;

    if (stop) begin
      state_d  = StIdle;
      number_d = BLANK;
    end else begin
      unique case (state_q)
        StIdle: begin
          number_d = BLANK;
          if (start) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end
        StGap: begin
          number_d = BLANK;
          if (cnt_q == '0) state_d = StPick;
          else             cnt_d   = cnt_q - CntW'(1);
        end
        StPick: begin
          if (cand < NumHoles5 && cand != prev_q) begin
            state_d  = StUp;
            number_d = cand;
            prev_d   = cand;
            cnt_d    = UpLoad;
          end
        end
        StUp: begin
          wrong_d = wrong_c;
          if (hit_c || cnt_q == '0) begin
            // A hit on the last visible cycle wins over the timeout.
            hit_d    = hit_c;
            miss_d   = ~hit_c;
            state_d  = StGap;
            cnt_d    = GapLoad;
            number_d = BLANK;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: begin
          state_d  = StIdle;
          number_d = BLANK;
        end
      endcase
    end

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      number_q <= BLANK;
      prev_q   <= BLANK;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      wrong_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      number_q <= number_d;
      prev_q   <= prev_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      wrong_q  <= wrong_d;
      active_q <= active_d;
    end
  end

  assign number    = number_q;
  assign mole_hit  = hit_q;
  assign mole_miss = miss_q;
  assign wrong_hit = wrong_q;
  assign active    = active_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with short windows (UP=8, GAP=4) and the default seed.
// A reference LFSR predicts each picked hole and the length of each blank interval.
module tb_mole_spawner;

  localparam int unsigned Up    = 8;
  localparam int unsigned Gap   = 4;
  localparam logic [4:0]  Blank = 5'd31;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [17:0] hit_req;
  logic [4:0]  number;
  logic        mole_hit;
  logic        mole_miss;
  logic        wrong_hit;
  logic        active;

  int checks;
  int errors;
  logic [15:0] model;
  logic [4:0]  prev_m;

  mole_spawner #(
    .NUM_HOLES (18),
    .UP_CYCLES (Up),
    .GAP_CYCLES(Gap)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .hit_req  (hit_req),
    .number   (number),
    .mole_hit (mole_hit),
    .mole_miss(mole_miss),
    .wrong_hit(wrong_hit),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference x^16+x^14+x^13+x^11+1 Galois LFSR, free-running after reset.
  always @(posedge clk) begin
    if (!rst_n) model <= 16'hACE1;
    else        model <= {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first blank cycle after a start or a mole; returns on the first UP cycle.
  task automatic run_gap(output logic [4:0] pos);
    logic [15:0] hist[$];
    int          blanks;
    int          exp_blanks;
    logic [4:0]  exp_pos;
    blanks     = 0;
    exp_blanks = -1;
    exp_pos    = Blank;
    while (number === Blank && blanks < 300) begin
      hist.push_back(model);
      if (blanks == 1) begin
        checks++;
        if ({mole_hit, mole_miss, wrong_hit} !== 3'b000) begin
          errors++;
          $display("FAIL gap_pulses got %b want 000", {mole_hit, mole_miss, wrong_hit});
        end
      end
      tick();
      blanks++;
    end
    for (int j = Gap; j < hist.size(); j++) begin
      if (exp_blanks < 0 && hist[j][4:0] < 5'd18 && hist[j][4:0] != prev_m) begin
        exp_blanks = j + 1;
        exp_pos    = hist[j][4:0];
      end
    end
    checks++;
    if (blanks != exp_blanks) begin
      errors++;
      $display("FAIL blank_len got %0d want %0d", blanks, exp_blanks);
    end
    checks++;
    if (number !== exp_pos) begin
      errors++;
      $display("FAIL picked_hole got %0d want %0d", number, exp_pos);
    end
    checks++;
    if (!(number < 5'd18) || number === prev_m) begin
      errors++;
      $display("FAIL hole_valid got %0d want <18 and not %0d", number, prev_m);
    end
    prev_m = number;
    pos    = number;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; hit_req = '0;
    repeat (3) tick();
    checks++;
    if ({number, active, mole_hit, mole_miss, wrong_hit} !== {Blank, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got num=%0d act=%b pulses=%b want num=31 act=0 pulses=000",
               number, active, {mole_hit, mole_miss, wrong_hit});
    end
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (number !== Blank || active !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got num=%0d act=%b want num=31 act=0", number, active);
    end
  endtask

  task automatic test_start(output logic [4:0] pos);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (active !== 1'b1 || number !== Blank) begin
      errors++;
      $display("FAIL start got act=%b num=%0d want act=1 num=31", active, number);
    end
    run_gap(pos);
  endtask

  task automatic test_miss(inout logic [4:0] pos);
    int          up_cnt;
    logic [4:0]  old;
    logic        bad_pulse;
    old       = pos;
    up_cnt    = 1;
    bad_pulse = 1'b0;
    tick();
    while (number === pos && up_cnt < 20) begin
      if (mole_hit || mole_miss || wrong_hit) bad_pulse = 1'b1;
      up_cnt++;
      tick();
    end
    checks++;
    if (up_cnt != Up || bad_pulse) begin
      errors++;
      $display("FAIL up_window got %0d cycles pulse=%b want %0d cycles pulse=0",
               up_cnt, bad_pulse, Up);
    end
    checks++;
    if ({mole_miss, mole_hit, number} !== {2'b10, Blank}) begin
      errors++;
      $display("FAIL miss_pulse got miss=%b hit=%b num=%0d want miss=1 hit=0 num=31",
               mole_miss, mole_hit, number);
    end
    run_gap(pos);
    checks++;
    if (pos === old) begin
      errors++;
      $display("FAIL no_repeat got %0d want not %0d", pos, old);
    end
  endtask

  task automatic test_hit(inout logic [4:0] pos);
    tick();
    tick();
    hit_req = 18'd1 << pos;
    tick();
    hit_req = '0;
    checks++;
    if ({mole_hit, wrong_hit, mole_miss, number} !== {3'b100, Blank}) begin
      errors++;
      $display("FAIL hit_3rd got hit=%b wrong=%b miss=%b num=%0d want 1 0 0 31",
               mole_hit, wrong_hit, mole_miss, number);
    end
    run_gap(pos);
  endtask

  task automatic test_double_hit(inout logic [4:0] pos);
    hit_req = (18'd1 << pos) | (18'd1 << ((pos + 1) % 18));
    tick();
    hit_req = '0;
    checks++;
    if ({mole_hit, wrong_hit, mole_miss, number} !== {3'b110, Blank}) begin
      errors++;
      $display("FAIL hit_plus_wrong got hit=%b wrong=%b miss=%b num=%0d want 1 1 0 31",
               mole_hit, wrong_hit, mole_miss, number);
    end
    run_gap(pos);
  endtask

  task automatic test_final_hit(inout logic [4:0] pos);
    repeat (Up - 1) tick();
    checks++;
    if (number !== pos) begin
      errors++;
      $display("FAIL last_up_cycle got %0d want %0d", number, pos);
    end
    hit_req = 18'd1 << pos;
    tick();
    hit_req = '0;
    checks++;
    if ({mole_hit, mole_miss, number} !== {2'b10, Blank}) begin
      errors++;
      $display("FAIL final_hit got hit=%b miss=%b num=%0d want hit=1 miss=0 num=31",
               mole_hit, mole_miss, number);
    end
    run_gap(pos);
  endtask

  task automatic test_wrong_and_stop(input logic [4:0] pos);
    hit_req = 18'd1 << ((pos + 5) % 18);
    tick();
    hit_req = '0;
    checks++;
    if ({wrong_hit, mole_hit, number} !== {2'b10, pos}) begin
      errors++;
      $display("FAIL wrong_only got wrong=%b hit=%b num=%0d want wrong=1 hit=0 num=%0d",
               wrong_hit, mole_hit, number, pos);
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({active, number, mole_hit, mole_miss, wrong_hit} !== {1'b0, Blank, 3'b000}) begin
      errors++;
      $display("FAIL stop_up got act=%b num=%0d pulses=%b want act=0 num=31 pulses=000",
               active, number, {mole_hit, mole_miss, wrong_hit});
    end
    hit_req = '1;
    tick();
    hit_req = '0;
    checks++;
    if (wrong_hit !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL idle_hit_ignored got wrong=%b act=%b want 0 0", wrong_hit, active);
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    checks++;
    if (active !== 1'b0 || number !== Blank) begin
      errors++;
      $display("FAIL start_with_stop got act=%b num=%0d want act=0 num=31", active, number);
    end
  endtask

  task automatic test_back_to_back(inout logic [4:0] pos);
    for (int k = 0; k < 200; k++) begin
      hit_req = 18'd1 << pos;
      tick();
      hit_req = '0;
      checks++;
      if (mole_hit !== 1'b1 || number !== Blank) begin
        errors++;
        $display("FAIL b2b_hit[%0d] got hit=%b num=%0d want hit=1 num=31", k, mole_hit, number);
      end
      run_gap(pos);
    end
  endtask

  task automatic test_reset_mid_up();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({number, active, mole_hit, mole_miss, wrong_hit} !== {Blank, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_up got num=%0d act=%b pulses=%b want num=31 act=0 pulses=000",
               number, active, {mole_hit, mole_miss, wrong_hit});
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [4:0] pos;
    checks = 0;
    errors = 0;
    prev_m = Blank;
    test_reset();
    test_start(pos);
    test_miss(pos);
    test_hit(pos);
    test_double_hit(pos);
    test_final_hit(pos);
    test_wrong_and_stop(pos);
    test_start_stop_idle();
    test_start(pos);
    test_back_to_back(pos);
    test_reset_mid_up();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
